// File: rtl/p18_layer_sequencer_if.sv
// Bus between the game logic and the layer sequencer: event pulses in,
// per-layer show masks, border override and status out.
interface p18_layer_sequencer_if;
  logic       frame_start;
  logic       start;
  logic       life_lost;
  logic       level_clear;
  logic [1:0] lives_left;
  logic       ball_show;
  logic       paddle_show;
  logic       blocks_show;
  logic       lives_show;
  logic       border_ovr;
  logic [5:0] border_color;
  logic       busy;
  logic [2:0] state_o;
  logic       freeze;

  // Game-logic side: issues events, observes display/status.
  modport master (
    output frame_start, start, life_lost, level_clear, lives_left,
    input  ball_show, paddle_show, blocks_show, lives_show,
    input  border_ovr, border_color, busy, state_o, freeze
  );

  // Sequencer side.
  modport slave (
    input  frame_start, start, life_lost, level_clear, lives_left,
    output ball_show, paddle_show, blocks_show, lives_show,
    output border_ovr, border_color, busy, state_o, freeze
  );
endinterface

// File: rtl/p18_layer_sequencer.sv
// Frame-synchronous display-state controller for the layer video mux.
// Tracks IDLE/PLAY/BLINK/FLASH/OVER and drives per-layer show masks and a
// border colour override; display registers only change on frame_start so no
// layer switches mid-frame.
// Optional feature: define P18_SEQ_FREEZE_EN to drive freeze high while the
// state is BLINK, FLASH or OVER; otherwise freeze is tied low.
module p18_layer_sequencer #(
  parameter int          BLINK_FRAMES  = 8,
  parameter int          BLINK_COUNT   = 3,
  parameter int          FLASH_FRAMES  = 32,
  parameter int          FLASH_PERIOD  = 4,
  parameter logic [5:0]  FLASH_COLOR_A = 6'h3F,
  parameter logic [5:0]  FLASH_COLOR_B = 6'h30,
  parameter logic [5:0]  OVER_COLOR    = 6'h03
) (
  input logic                 clk,
  input logic                 rst,
  p18_layer_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_BLINK = 3'd2,
    S_FLASH = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  // frame_cnt is shared by BLINK and FLASH; phase_cnt counts on/off phases in
  // BLINK and frames within a colour phase in FLASH.
  localparam int BFW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int FFW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam int FCW = (BFW > FFW) ? BFW : FFW;
  localparam int BPW = (2 * BLINK_COUNT > 1) ? $clog2(2 * BLINK_COUNT) : 1;
  localparam int FPW = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
  localparam int PCW = (BPW > FPW) ? BPW : FPW;

  localparam logic [FCW-1:0] BLINK_LAST  = FCW'(BLINK_FRAMES - 1);
  localparam logic [FCW-1:0] FLASH_LAST  = FCW'(FLASH_FRAMES - 1);
  localparam logic [PCW-1:0] BPHASE_LAST = PCW'(2 * BLINK_COUNT - 1);
  localparam logic [PCW-1:0] FPHASE_LAST = PCW'(FLASH_PERIOD - 1);

  state_t           state_q, state_d;
  logic [FCW-1:0]   frame_cnt_q, frame_cnt_d;
  logic [PCW-1:0]   phase_cnt_q, phase_cnt_d;
  logic             phase_q, phase_d;

  logic             ball_show_q, ball_show_d;
  logic             paddle_show_q, paddle_show_d;
  logic             blocks_show_q, blocks_show_d;
  logic             lives_show_q, lives_show_d;
  logic             border_ovr_q, border_ovr_d;
  logic [5:0]       border_color_q, border_color_d;

  // State and sequence counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      frame_cnt_q <= '0;
      phase_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      phase_cnt_q <= phase_cnt_d;
      phase_q     <= phase_d;
    end
  end

  // Next-state logic; level_clear is checked first so it wins over life_lost.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    phase_cnt_d = phase_cnt_q;
    phase_d     = phase_q;
    unique case (state_q)
      S_IDLE, S_OVER: begin
        if (bus.start) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (bus.level_clear) begin
          state_d     = S_FLASH;
          frame_cnt_d = '0;
          phase_cnt_d = '0;
          phase_d     = 1'b0;
        end else if (bus.life_lost) begin
          if (bus.lives_left != 2'd0) begin
            state_d     = S_BLINK;
            frame_cnt_d = '0;
            phase_cnt_d = '0;
            phase_d     = 1'b0;
          end else begin
            state_d = S_OVER;
          end
        end
      end
      S_BLINK: begin
        if (bus.frame_start) begin
          if (frame_cnt_q == BLINK_LAST) begin
            frame_cnt_d = '0;
            phase_d     = ~phase_q;
            if (phase_cnt_q == BPHASE_LAST) begin
              state_d = S_PLAY;
            end else begin
              phase_cnt_d = phase_cnt_q + 1'b1;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      S_FLASH: begin
        if (bus.frame_start) begin
          if (frame_cnt_q == FLASH_LAST) begin
            state_d = S_PLAY;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
          if (phase_cnt_q == FPHASE_LAST) begin
            phase_cnt_d = '0;
            phase_d     = ~phase_q;
          end else begin
            phase_cnt_d = phase_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Display registers: decode the current (pre-transition) state on frame_start only.
  always_comb begin
    ball_show_d    = ball_show_q;
    paddle_show_d  = paddle_show_q;
    blocks_show_d  = blocks_show_q;
    lives_show_d   = lives_show_q;
    border_ovr_d   = border_ovr_q;
    border_color_d = border_color_q;
    if (bus.frame_start) begin
      ball_show_d    = 1'b0;
      paddle_show_d  = 1'b0;
      blocks_show_d  = 1'b1;
      lives_show_d   = 1'b0;
      border_ovr_d   = 1'b0;
      border_color_d = 6'h00;
      unique case (state_q)
        S_PLAY: begin
          ball_show_d   = 1'b1;
          paddle_show_d = 1'b1;
          lives_show_d  = 1'b1;
        end
        S_BLINK: begin
          paddle_show_d = phase_q;
          lives_show_d  = 1'b1;
        end
        S_FLASH: begin
          paddle_show_d  = 1'b1;
          blocks_show_d  = 1'b0;
          lives_show_d   = 1'b1;
          border_ovr_d   = 1'b1;
          border_color_d = phase_q ? FLASH_COLOR_B : FLASH_COLOR_A;
        end
        S_OVER: begin
          border_ovr_d   = 1'b1;
          border_color_d = OVER_COLOR;
        end
        default: ;
      endcase
    end
  end

  // Display register bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ball_show_q    <= 1'b0;
      paddle_show_q  <= 1'b0;
      blocks_show_q  <= 1'b0;
      lives_show_q   <= 1'b0;
      border_ovr_q   <= 1'b0;
      border_color_q <= 6'h00;
    end else begin
      ball_show_q    <= ball_show_d;
      paddle_show_q  <= paddle_show_d;
      blocks_show_q  <= blocks_show_d;
      lives_show_q   <= lives_show_d;
      border_ovr_q   <= border_ovr_d;
      border_color_q <= border_color_d;
    end
  end

`ifdef P18_SEQ_FREEZE_EN
  logic freeze_q, freeze_d;

  // freeze tracks the next state so it switches on the same edge as state_q.
  always_comb begin
    freeze_d = (state_d == S_BLINK) || (state_d == S_FLASH) || (state_d == S_OVER);
  end

  // Freeze register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) freeze_q <= 1'b0;
    else     freeze_q <= freeze_d;
  end

  assign bus.freeze = freeze_q;
`else
  assign bus.freeze = 1'b0;
`endif

  assign bus.ball_show    = ball_show_q;
  assign bus.paddle_show  = paddle_show_q;
  assign bus.blocks_show  = blocks_show_q;
  assign bus.lives_show   = lives_show_q;
  assign bus.border_ovr   = border_ovr_q;
  assign bus.border_color = border_color_q;
  assign bus.busy         = (state_q == S_BLINK) || (state_q == S_FLASH);
  assign bus.state_o      = state_q;

endmodule

// File: tb/tb_p18_layer_sequencer.sv
// Directed bench for p18_layer_sequencer: reset, PLAY entry, BLINK and FLASH
// sequences, OVER, coincident frame_start, and asynchronous mid-sequence reset.
module tb_p18_layer_sequencer;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  p18_layer_sequencer_if bus ();

  p18_layer_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef P18_SEQ_FREEZE_EN
  localparam logic FRZ = 1'b1;
`else
  localparam logic FRZ = 1'b0;
`endif

  // One comparison; masks packed as {ball,paddle,blocks,lives,ovr} where used.
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] masks();
    return {3'b000, bus.ball_show, bus.paddle_show, bus.blocks_show,
            bus.lives_show, bus.border_ovr};
  endfunction

  // Hold the given pulses for exactly one rising edge, sample afterwards.
  task automatic drive(input logic fs, input logic st, input logic ll, input logic lc);
    @(negedge clk);
    bus.frame_start = fs;
    bus.start       = st;
    bus.life_lost   = ll;
    bus.level_clear = lc;
    @(negedge clk);
    bus.frame_start = 1'b0;
    bus.start       = 1'b0;
    bus.life_lost   = 1'b0;
    bus.level_clear = 1'b0;
  endtask

  task automatic frame();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.frame_start = 1'b0;
    bus.start       = 1'b0;
    bus.life_lost   = 1'b0;
    bus.level_clear = 1'b0;
    bus.lives_left  = 2'd2;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_state", {5'b0, bus.state_o}, 8'd0);
    chk("rst_masks", masks(), 8'h00);
    chk("rst_color", {2'b0, bus.border_color}, 8'h00);
    chk("rst_busy_freeze", {6'b0, bus.busy, bus.freeze}, 8'h00);
    rst = 1'b0;

    // IDLE frame, life_lost ignored in IDLE
    frame();
    chk("idle_masks", masks(), 8'b00100);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("idle_ignore_ll", {5'b0, bus.state_o}, 8'd0);

    // start -> PLAY, masks wait for the next frame
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("play_state", {5'b0, bus.state_o}, 8'd1);
    chk("play_masks_hold", masks(), 8'b00100);
    frame();
    chk("play_masks", masks(), 8'b11110);

    // BLINK: 48 frames, paddle toggles every 8 frames starting hidden
    bus.lives_left = 2'd2;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("blink_state", {5'b0, bus.state_o}, 8'd2);
    chk("blink_busy", {7'b0, bus.busy}, 8'd1);
    chk("blink_freeze", {7'b0, bus.freeze}, {7'b0, FRZ});
    for (int k = 1; k <= 48; k++) begin
      frame();
      chk($sformatf("blink_masks_f%0d", k), masks(),
          {5'b0, 1'b0, 1'(((k - 1) / 8) % 2), 1'b1, 1'b1, 1'b0});
      chk($sformatf("blink_state_f%0d", k), {5'b0, bus.state_o},
          (k < 48) ? 8'd2 : 8'd1);
    end
    chk("blink_done_busy", {7'b0, bus.busy}, 8'd0);
    frame();
    chk("blink_after_masks", masks(), 8'b11110);

    // FLASH: life_lost + level_clear together, colour 3F/30 every 4 frames
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    chk("flash_state", {5'b0, bus.state_o}, 8'd3);
    chk("flash_busy", {7'b0, bus.busy}, 8'd1);
    for (int k = 1; k <= 32; k++) begin
      frame();
      chk($sformatf("flash_masks_f%0d", k), masks(), 8'b01011);
      chk($sformatf("flash_color_f%0d", k), {2'b0, bus.border_color},
          ((((k - 1) / 4) % 2) == 1) ? 8'h30 : 8'h3F);
      chk($sformatf("flash_state_f%0d", k), {5'b0, bus.state_o},
          (k < 32) ? 8'd3 : 8'd1);
    end
    frame();
    chk("flash_after_masks", masks(), 8'b11110);
    chk("flash_after_color", {2'b0, bus.border_color}, 8'h00);

    // life_lost coincident with frame_start: this frame still PLAY
    bus.lives_left = 2'd1;
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    chk("coinc_state", {5'b0, bus.state_o}, 8'd2);
    chk("coinc_masks", masks(), 8'b11110);
    frame();
    chk("coinc_next_masks", masks(), 8'b00110);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("blink_ignore_start", {5'b0, bus.state_o}, 8'd2);

    // Asynchronous reset mid-sequence
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", {5'b0, bus.state_o}, 8'd0);
    chk("arst_masks", masks(), 8'h00);
    chk("arst_busy_freeze", {6'b0, bus.busy, bus.freeze}, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Back to PLAY; start in PLAY ignored
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("play_ignore_start", {5'b0, bus.state_o}, 8'd1);
    frame();
    chk("play2_masks", masks(), 8'b11110);

    // OVER: last life lost
    bus.lives_left = 2'd0;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("over_state", {5'b0, bus.state_o}, 8'd4);
    chk("over_busy", {7'b0, bus.busy}, 8'd0);
    chk("over_freeze", {7'b0, bus.freeze}, {7'b0, FRZ});
    frame();
    chk("over_masks", masks(), 8'b00101);
    chk("over_color", {2'b0, bus.border_color}, 8'h03);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    chk("over_ignore_ev", {5'b0, bus.state_o}, 8'd4);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("over_restart", {5'b0, bus.state_o}, 8'd1);
    chk("over_restart_freeze", {7'b0, bus.freeze}, 8'd0);
    frame();
    chk("restart_masks", masks(), 8'b11110);
    chk("restart_color", {2'b0, bus.border_color}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
